// File: rtl/cmp_sort_ctrl_if.sv
// Load/read/launch bundle for the cmp_sort_ctrl bubble-sort engine.
// The master side drives writes, reads and start; the slave is the engine.
interface cmp_sort_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              start;
    logic              descend;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              busy;
    logic              done;
    logic [7:0]        swap_cnt;
    logic [1:0]        dbg_state;

    // start is a single-cycle request taken only when the engine is idle;
    // busy covers every compare/swap cycle and done pulses once at completion.
    modport master (
        output wr_en, wr_addr, wr_data, start, descend, rd_addr,
        input  rd_data, busy, done, swap_cnt, dbg_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, descend, rd_addr,
        output rd_data, busy, done, swap_cnt, dbg_state
    );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// Bubble-sort engine sharing one unsigned greater-than comparator over a register array.
// Optional macro CMP_SORT_EARLY_EXIT_EN ends the sort after a pass with no swaps.
module cmp_sort_ctrl #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    cmp_sort_ctrl_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

`ifdef CMP_SORT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMP    = 2'd1,
        SWAP   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] i_q;
    logic [ADDR_W-1:0] limit_q;
    logic              swapped_q;
    logic              descend_q;
    logic [7:0]        swap_cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  rd_data_q;

    logic [ADDR_W-1:0] i_inc;
    logic [WIDTH-1:0]  elem_a;
    logic [WIDTH-1:0]  elem_b;
    logic [WIDTH-1:0]  cmp_lhs;
    logic [WIDTH-1:0]  cmp_rhs;
    logic              need_swap;
    logic              do_advance;
    logic              pass_end;
    logic              swapped_now;
    logic              adv_finish;

    assign i_inc  = i_q + 1'b1;
    assign elem_a = mem_q[i_q];
    assign elem_b = mem_q[i_inc];

    // Order is folded into the operand mux so only one comparator exists.
    assign cmp_lhs   = descend_q ? elem_b : elem_a;
    assign cmp_rhs   = descend_q ? elem_a : elem_b;
    assign need_swap = cmp_lhs > cmp_rhs;

    assign do_advance  = (state_q == SWAP) || ((state_q == CMP) && !need_swap);
    assign pass_end    = !(i_inc < limit_q);
    assign swapped_now = swapped_q || (state_q == SWAP);
    assign adv_finish  = pass_end &&
                         ((limit_q == ADDR_W'(1)) || (EARLY_EXIT && !swapped_now));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            i_q        <= '0;
            limit_q    <= '0;
            swapped_q  <= 1'b0;
            descend_q  <= 1'b0;
            swap_cnt_q <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_data_q <= mem_q[bus.rd_addr];
            done_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.wr_en) begin
                        mem_q[bus.wr_addr] <= bus.wr_data;
                    end
                    if (bus.start) begin
                        state_q    <= CMP;
                        i_q        <= '0;
                        limit_q    <= LAST_IDX;
                        swapped_q  <= 1'b0;
                        swap_cnt_q <= 8'd0;
                        descend_q  <= bus.descend;
                        busy_q     <= 1'b1;
                    end
                end
                CMP: begin
                    if (need_swap) begin
                        state_q <= SWAP;
                    end
                end
                SWAP: begin
                    mem_q[i_q]   <= elem_b;
                    mem_q[i_inc] <= elem_a;
                    swapped_q    <= 1'b1;
                    if (swap_cnt_q != 8'hFF) begin
                        swap_cnt_q <= swap_cnt_q + 8'd1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Shared step after a non-swapping compare or a completed swap;
            // a new pass clears the swapped flag set just above.
            if (do_advance) begin
                if (adv_finish) begin
                    state_q <= FINISH;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else if (pass_end) begin
                    state_q   <= CMP;
                    limit_q   <= limit_q - 1'b1;
                    i_q       <= '0;
                    swapped_q <= 1'b0;
                end else begin
                    state_q <= CMP;
                    i_q     <= i_inc;
                end
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.swap_cnt  = swap_cnt_q;
    assign bus.dbg_state = state_q;
endmodule

// File: doc/cmp_sort_ctrl.md
Name: cmp_sort_ctrl

Overview:
Sequential sort engine for a small on-chip array of unsigned values. A single shared unsigned greater-than comparator is used at most once per cycle. A bubble-sort FSM sequences that comparator over a register array. It is loaded and read through simple address/data ports and is launched with a start/busy/done handshake. It serves as the sequencing controller for the team's magnitude-comparator datapath.

Parameters:
WIDTH, 4, element width in bits; compare is unsigned strict greater-than.
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries. Legal range is 1..4.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
wr_en  input  1  write strobe for the array
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
start  input  1  launch a sort; sampled only in IDLE
descend  input  1  sort order, latched at start: 0 = ascending, 1 = descending
rd_addr  input  ADDR_W  read address
rd_data  output  WIDTH  registered read data, 1-cycle latency
busy  output  1  high while a sort is in progress
done  output  1  1-cycle pulse when a sort completes
swap_cnt  output  8  swaps performed by the last/current sort; saturates at 255

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE; all array entries become 0.
  - rd_data=0, busy=0, done=0, swap_cnt=0, latched order=ascending.
  - Reset mid-sort aborts the sort; busy=0 from the next cycle.
- FSM states: IDLE, CMP, SWAP, FINISH.
- IDLE:
  - wr_en writes mem[wr_addr].
  - When start=1, the next state is CMP and the engine sets:
    - i=0, limit=DEPTH-1, swapped=0, swap_cnt=0;
    - latched order = descend.
  - If start and wr_en occur in the same cycle, the write is performed and the sort starts next cycle using the written value.
- CMP (one compare per cycle):
  - need_swap = ascending ? (mem[i] > mem[i+1]) : (mem[i+1] > mem[i]).
  - Equal values never swap, so the sort is stable.
  - need_swap=1 -> SWAP.
  - need_swap=0 -> advance.
- SWAP (one cycle):
  - exchange mem[i] and mem[i+1];
  - set swapped=1;
  - swap_cnt = swap_cnt+1, saturating at 255;
  - then advance.
- Advance:
  - If i+1 < limit: i=i+1, go to CMP.
  - Otherwise the pass ends:
    - limit==1 -> FINISH;
    - else, with CMP_SORT_EARLY_EXIT_EN, swapped==0 -> FINISH;
    - else limit=limit-1, i=0, swapped=0, go to CMP.
- FINISH: done=1 and busy=0 for one cycle, then IDLE. swap_cnt holds until the next start.
- busy=1 exactly in the CMP and SWAP states.
- Busy cycles = compares + swaps.
- DEPTH=1 (ADDR_W=0 is illegal): not supported.
- While busy:
  - wr_en is ignored (array not modified);
  - start is ignored;
  - descend is ignored.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, including during a sort (shows in-progress contents).
  - A read and a write to the same address in the same cycle return the old value.

Optional Feature:
CMP_SORT_EARLY_EXIT_EN:
- Defined: a pass that completes with no swap ends the sort, so a pre-sorted array takes DEPTH-1 busy cycles.
- Undefined: every sort runs all DEPTH-1 passes, giving DEPTH*(DEPTH-1)/2 compares. Latency then depends only on swap count; the final array and swap_cnt are identical in both builds.

Test Plan:
1. Reset low for 1 cycle, then read addresses 0..7 -> rd_data=0 each (1 cycle after rd_addr); busy=0, done=0, swap_cnt=0.
2. Load 7,6,5,4,3,2,1,0, start with descend=0 -> busy high 56 cycles, done pulse once, swap_cnt=28, array reads 0,1,...,7.
3. Load 0..7 ascending, start with descend=0 -> swap_cnt=0, array unchanged. Busy lasts 7 cycles with CMP_SORT_EARLY_EXIT_EN, 28 cycles without.
4. Load 3,9,3,15,0,9,1,1, start with descend=1 -> array 15,9,9,3,3,1,1,0; done pulses exactly once.
5. Comparator boundaries: load 8,7,5,4,15,0,14,15 ascending -> 0,4,5,7,8,14,15,15. This covers MSB-only (8 vs 7), bit0-only (5 vs 4) and equal (15,15) cases.
6. During busy, drive wr_en=1 to addr 0 with data 0xF and pulse start -> both ignored and the result matches a clean sort. A later case deasserts reset mid-sort -> busy=0 next cycle and all entries read 0.
